// File: rtl/act_share_pkg.sv
// Shared types and constants for the tanh-core sharing arbiter.
package act_share_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Result returned to a requester whose element timed out in the core
    localparam logic [DEFAULT_DATA_WIDTH-1:0] TIMEOUT_RESULT = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/act_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, with wrap.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  grant,
    output logic            any_valid
);

    int              idx;
    logic [IDW-1:0]  pidx;

    // Scan offsets from farthest to nearest so the closest valid requester wins
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        pidx      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx  = (int'(rr_ptr) + k) % NREQ;
            pidx = IDW'(idx);
            if (req_valid[pidx]) begin
                grant     = pidx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/act_share_arbiter.sv
// Round-robin sequencer sharing one iterative tanh core between NREQ requesters.
// Optional WAIT watchdog enabled by defining ACT_SHARE_TIMEOUT_EN.
module act_share_arbiter
    import act_share_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int NREQ        = 4,
    parameter int IDW         = 2
`ifdef ACT_SHARE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [DATA_WIDTH-1:0]      core_x,
    output logic                       core_reset,
    input  logic [DATA_WIDTH-1:0]      core_out,
    input  logic                       core_finished,
    output logic                       busy,
    output logic [IDW-1:0]             grant_id
`ifdef ACT_SHARE_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  pick_id;
    logic            pick_any;
    logic            timeout_hit;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_id),
        .any_valid (pick_any)
    );

`ifdef ACT_SHARE_TIMEOUT_EN
    logic [15:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != ST_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == ST_WAIT) && !core_finished &&
                         (wait_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (pick_any) state_nxt = ST_LAUNCH;
            ST_LAUNCH: state_nxt = ST_WAIT;
            ST_WAIT:   if (core_finished || timeout_hit) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are gated by reset so an abandoned element never emits a response
    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        core_reset = reset || (state != ST_WAIT);
        busy       = !reset && (state != ST_IDLE);
        if (!reset && state == ST_IDLE && pick_any) begin
            req_ready[pick_id] = 1'b1;
        end
        if (!reset && state == ST_RESP) begin
            rsp_valid[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_x   <= '0;
            rsp_data <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        core_x   <= req_data[DATA_WIDTH*pick_id +: DATA_WIDTH];
                        grant_id <= pick_id;
                    end
                end
                ST_WAIT: begin
                    if (core_finished) begin
                        rsp_data <= core_out;
                    end else if (timeout_hit) begin
                        rsp_data <= {DATA_WIDTH{TIMEOUT_RESULT[0]}};
                    end
                end
                ST_RESP: begin
                    rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_act_share_arbiter.sv
// Self-checking bench for act_share_arbiter with a behavioural stand-in tanh core.
// Define ACT_SHARE_TIMEOUT_EN to also exercise the WAIT watchdog (TIMEOUT_CYC=16).
module tb_act_share_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic [31:0]  core_x;
    logic         core_reset;
    logic [31:0]  core_out;
    logic         core_finished;
    logic         busy;
    logic [1:0]   grant_id;
`ifdef ACT_SHARE_TIMEOUT_EN
    logic         timeout_err;
`endif

    logic [31:0]  opnd [4];
    int           checks = 0;
    int           failures = 0;

    typedef struct {
        logic [3:0]  onehot;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [3:0] rdy;
        logic       crst;
        logic       bsy;
        logic [3:0] rsp;
    } vec_t;
    vec_t vecs [9];

    int         core_lat = 5;
    logic       core_hold = 1'b0;
    int         core_cnt = 0;
    logic       auto_drop = 1'b1;
    logic       cont = 1'b0;
    logic [3:0] clr = '0;
    logic [3:0] adv = '0;
    int         accepts = 0;
    int         opcnt [4];

    assign req_data = {opnd[3], opnd[2], opnd[1], opnd[0]};

    act_share_arbiter #(
        .DATA_WIDTH (32),
        .NREQ       (4),
        .IDW        (2)
`ifdef ACT_SHARE_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (16)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .core_x        (core_x),
        .core_reset    (core_reset),
        .core_out      (core_out),
        .core_finished (core_finished),
        .busy          (busy),
        .grant_id      (grant_id)
`ifdef ACT_SHARE_TIMEOUT_EN
        ,
        .timeout_err   (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tanh_model(input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Stand-in core: counts cycles out of reset, finishes after core_lat cycles
    assign core_out      = tanh_model(core_x);
    assign core_finished = !core_hold && !core_reset && (core_cnt >= core_lat - 1);
    always @(posedge clk) core_cnt <= core_reset ? 0 : core_cnt + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Negedge sample point: scoreboard compare plus requester bookkeeping
    task automatic waitNeg();
        exp_t e;
        @(negedge clk);
        if (rsp_valid !== 4'b0000) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput("rsp_valid", 64'(rsp_valid), 64'(e.onehot));
                checkOutput("rsp_data", 64'(rsp_data), 64'(e.data));
                checkOutput("grant_id", 64'(4'b0001 << grant_id), 64'(e.onehot));
            end
        end
        clr = auto_drop ? req_ready : 4'b0000;
        adv = cont ? req_ready : 4'b0000;
        if (req_ready != 4'b0000) accepts++;
    endtask

    task automatic stepPos();
        @(posedge clk);
        #1;
        if (cont) begin
            for (int i = 0; i < 4; i++) begin
                if (adv[i]) begin
                    opcnt[i]++;
                    opnd[i] = (32'(i) << 24) | 32'(opcnt[i]);
                end
            end
            if (accepts >= 6) req_valid = 4'b0000;
        end else begin
            req_valid = req_valid & ~clr;
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            waitNeg();
            stepPos();
        end
    endtask

    task automatic drain(input int budget);
        int b;
        b = 0;
        while (sbq.size() != 0 && b < budget) begin
            waitNeg();
            stepPos();
            b++;
        end
        checkOutput("drain_done", 64'(sbq.size()), 64'd0);
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) opnd[i] = base + 32'(i);
        end
        req_valid = req_valid | mask;
    endtask

    initial begin
`ifdef ACT_SHARE_TIMEOUT_EN
        int n;
        logic seen;
`endif
        reset     = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            opnd[i]  = '0;
            opcnt[i] = 0;
        end
        vecs[0] = '{4'b0100, 1'b1, 1'b0, 4'b0000};
        vecs[1] = '{4'b0000, 1'b1, 1'b1, 4'b0000};
        vecs[2] = '{4'b0000, 1'b0, 1'b1, 4'b0000};
        vecs[3] = '{4'b0000, 1'b0, 1'b1, 4'b0000};
        vecs[4] = '{4'b0000, 1'b0, 1'b1, 4'b0000};
        vecs[5] = '{4'b0000, 1'b0, 1'b1, 4'b0000};
        vecs[6] = '{4'b0000, 1'b0, 1'b1, 4'b0000};
        vecs[7] = '{4'b0000, 1'b1, 1'b1, 4'b0100};
        vecs[8] = '{4'b0000, 1'b1, 1'b0, 4'b0000};

        repeat (2) @(posedge clk);
        #1;

        // Reset values, with a request already pending before release
        req_valid = 4'b0100;
        opnd[2]   = 32'h0001_0000;
        waitNeg();
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("rst_core_x", 64'(core_x), 64'd0);
        checkOutput("rst_core_reset", 64'(core_reset), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_grant_id", 64'(grant_id), 64'd0);
        stepPos();
        reset = 1'b0;

        // Single request, per-cycle control outputs from the vector table
        core_lat = 5;
        sbq.push_back('{4'b0100, tanh_model(32'h0001_0000)});
        for (int k = 0; k < 9; k++) begin
            waitNeg();
            checkOutput($sformatf("single_c%0d_req_ready", k + 1), 64'(req_ready), 64'(vecs[k].rdy));
            checkOutput($sformatf("single_c%0d_core_reset", k + 1), 64'(core_reset), 64'(vecs[k].crst));
            checkOutput($sformatf("single_c%0d_busy", k + 1), 64'(busy), 64'(vecs[k].bsy));
            checkOutput($sformatf("single_c%0d_rsp_valid", k + 1), 64'(rsp_valid), 64'(vecs[k].rsp));
            stepPos();
        end
        checkOutput("single_sb_empty", 64'(sbq.size()), 64'd0);

        // All four requesting continuously from reset: strictly cyclic order
        reset     = 1'b1;
        core_lat  = 2;
        cont      = 1'b1;
        auto_drop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            opcnt[i] = 0;
            opnd[i]  = 32'(i) << 24;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            sbq.push_back('{4'b0001 << (k % 4), tanh_model((32'(k % 4) << 24) | 32'(k / 4))});
        end
        runCycles(1);
        accepts = 0;
        reset   = 1'b0;
        drain(100);
        checkOutput("cont_accepts", 64'(accepts), 64'd6);
        cont      = 1'b0;
        auto_drop = 1'b1;
        req_valid = 4'b0000;
        runCycles(2);

        // Priority rotation: after serving req1, req3 beats req0
        core_lat = 3;
        sbq.push_back('{4'b0010, tanh_model(32'h11)});
        applyStimulus(4'b0010, 32'h10);
        drain(50);
        sbq.push_back('{4'b1000, tanh_model(32'h23)});
        sbq.push_back('{4'b0001, tanh_model(32'h20)});
        applyStimulus(4'b1001, 32'h20);
        waitNeg();
        checkOutput("rot_first_ready", 64'(req_ready), 64'(4'b1000));
        stepPos();
        drain(50);

        // Operand stability while the requester changes its data after accept
        core_lat = 4;
        sbq.push_back('{4'b0100, tanh_model(32'hCAFE_0001)});
        opnd[2]   = 32'hCAFE_0001;
        req_valid = 4'b0100;
        waitNeg();
        checkOutput("stab_ready", 64'(req_ready), 64'(4'b0100));
        stepPos();
        opnd[2] = 32'h1234_0000;
        checkOutput("stab_grant_id", 64'(grant_id), 64'd2);
        repeat (6) begin
            waitNeg();
            if (busy && rsp_valid == 4'b0000) begin
                checkOutput("core_x_stable", 64'(core_x), 64'h0000_0000_CAFE_0001);
            end
            stepPos();
        end
        drain(20);

        // Reset in WAIT abandons the element and rewinds the pointer to 0
        core_lat = 3;
        sbq.push_back('{4'b0010, tanh_model(32'h51)});
        applyStimulus(4'b0010, 32'h50);
        drain(50);
        core_lat  = 20;
        opnd[3]   = 32'h3333_0000;
        req_valid = 4'b1000;
        waitNeg();
        stepPos();
        runCycles(4);
        reset = 1'b1;
        waitNeg();
        checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("midrst_core_reset", 64'(core_reset), 64'd1);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        stepPos();
        reset = 1'b0;
        waitNeg();
        checkOutput("postrst_busy", 64'(busy), 64'd0);
        checkOutput("postrst_grant_id", 64'(grant_id), 64'd0);
        checkOutput("postrst_core_reset", 64'(core_reset), 64'd1);
        stepPos();
        runCycles(25);
        core_lat = 3;
        sbq.push_back('{4'b0010, tanh_model(32'h61)});
        sbq.push_back('{4'b1000, tanh_model(32'h63)});
        applyStimulus(4'b1010, 32'h60);
        waitNeg();
        checkOutput("postrst_first_ready", 64'(req_ready), 64'(4'b0010));
        stepPos();
        drain(50);

`ifdef ACT_SHARE_TIMEOUT_EN
        // Watchdog: core never finishes, element returns all-ones after 16 WAIT cycles
        checkOutput("to_err_clear", 64'(timeout_err), 64'd0);
        core_hold = 1'b1;
        sbq.push_back('{4'b0001, 32'hFFFF_FFFF});
        applyStimulus(4'b0001, 32'h5);
        waitNeg();
        stepPos();
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            waitNeg();
            n++;
            seen = (rsp_valid != 4'b0000);
            stepPos();
        end
        checkOutput("to_latency", 64'(n), 64'd18);
        checkOutput("to_err_set", 64'(timeout_err), 64'd1);
        core_hold = 1'b0;
        sbq.push_back('{4'b0100, tanh_model(32'h72)});
        applyStimulus(4'b0100, 32'h70);
        drain(50);
        checkOutput("to_err_sticky", 64'(timeout_err), 64'd1);
        reset = 1'b1;
        waitNeg();
        stepPos();
        reset = 1'b0;
        waitNeg();
        checkOutput("to_err_reset", 64'(timeout_err), 64'd0);
        stepPos();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/act_share_arbiter.md
Name: act_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one iterative HyperBolicTangent core between NREQ element-level requesters.
- Typical requesters are parallel FC-layer activation walkers.
- Each grant:
  - latches the requester's 32-bit operand;
  - pulses the core reset;
  - waits for the core's finished flag;
  - returns the result to the granted requester.
- Sits between the FC accumulators and the single tanh instance.

Parameters:
- DATA_WIDTH, 32, operand/result width (Q-format owned by the tanh core).
- NREQ, 4, number of requesters (2..16).
- IDW, 2, requester index width, must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  per-requester request, held until accepted.
- req_data  in  NREQ*DATA_WIDTH  operand; slice i is DATA_WIDTH*i +: DATA_WIDTH.
- req_ready  out  NREQ  one-hot accept pulse, one cycle.
- rsp_valid  out  NREQ  one-hot result strobe, one cycle.
- rsp_data  out  DATA_WIDTH  result, valid while rsp_valid is nonzero.
- core_x  out  DATA_WIDTH  operand to the tanh core.
- core_reset  out  1  tanh core reset.
- core_out  in  DATA_WIDTH  tanh core result.
- core_finished  in  1  tanh core done flag.
- busy  out  1  high in any state except IDLE.
- grant_id  out  IDW  index of the current or last granted requester.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, core_x=0, core_reset=1, busy=0, grant_id=0, rr_ptr=0; state is IDLE.
- Reset mid-operation abandons the element silently: no rsp_valid, core held in reset.
- FSM IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
- IDLE:
  - core_reset=1.
  - If any req_valid is set, pick the first set bit scanning from rr_ptr upward with wrap.
  - Pulse req_ready[g] for that cycle, latch req_data slice g into core_x, set grant_id=g, go to LAUNCH.
  - The requester must drop or advance req_valid the cycle after req_ready.
- LAUNCH (1 cycle): core_reset=1 with core_x stable; core_finished is ignored; go to WAIT.
- WAIT:
  - core_reset=0 and core_x stays stable.
  - On core_finished=1, latch core_out into rsp_data and go to RESP.
  - No upper bound on wait (see optional feature).
- RESP (1 cycle):
  - rsp_valid[grant_id]=1.
  - rr_ptr = grant_id+1, wrapping at NREQ to 0.
  - core_reset=1; go to IDLE.
- Throughput: one element every 3 + T_core cycles.
  - The IDLE accept cycle is counted, so a new requester is accepted on the cycle after RESP.
  - Back-to-back requests are serviced without gaps beyond this.
- Fairness: the requester just served has the lowest priority. With all NREQ requesting continuously, the service order is strictly cyclic.
- No new request is accepted outside IDLE; req_valid changes in other states are ignored.
- rsp_data holds its last value after RESP; only rsp_valid qualifies it.
- Requests arriving on the same cycle as reset deassertion are evaluated in the first IDLE cycle.

Optional Feature:
- Macro: ACT_SHARE_TIMEOUT_EN. It adds:
  - parameter TIMEOUT_CYC (default 1024);
  - a 16-bit WAIT-cycle counter;
  - output port timeout_err (1 bit, sticky, cleared only by reset).
- With the macro defined:
  - If WAIT lasts TIMEOUT_CYC cycles without core_finished, the FSM sets timeout_err=1.
  - It then forces rsp_data to all-ones ({DATA_WIDTH{1'b1}}) and goes to RESP, so the requester never hangs.
  - The core is re-reset through the normal LAUNCH path on the next grant.
- Without the macro: no counter, no port, and WAIT is unbounded.

Decomposition:
- Shared package act_share_pkg holds:
  - FSM state enum (IDLE, LAUNCH, WAIT, RESP) and its encoding;
  - the DATA_WIDTH default;
  - the all-ones timeout result constant.
- One natural sub-module: rr_pick. It is combinational and takes req_valid and rr_ptr. It returns the grant index and an any_valid flag.
- Build rr_pick standalone so it can be unit-tested separately.

Test Plan:
- Single request: req_valid=4'b0100, req_data[2] holding 0x00010000, core finishing 5 cycles after LAUNCH.
  - Expect req_ready=4'b0100 in cycle 1.
  - Expect core_reset high for 2 cycles (IDLE + LAUNCH).
  - Expect rsp_valid=4'b0100 with rsp_data equal to core_out.
  - Expect busy to fall on the next cycle.
- All four requesting continuously from reset: grants are exactly 0,1,2,3,0,1 and grant_id matches each rsp_valid bit.
- Priority rotation: serve req1, then assert req0 and req3 together.
  - Expect req3 to be granted first (rr_ptr=2), then req0.
- Operand stability: change req_data[g] after req_ready.
  - Expect core_x unchanged through LAUNCH and WAIT.
  - Expect rsp_data to reflect the original operand's result.
- Reset mid-WAIT: assert reset for 1 cycle.
  - Expect no rsp_valid, core_reset=1, state IDLE.
  - The next request is serviced normally from rr_ptr=0.
- With ACT_SHARE_TIMEOUT_EN and TIMEOUT_CYC=16, core_finished tied low:
  - Expect rsp_valid after 16 WAIT cycles with rsp_data=0xFFFFFFFF.
  - Expect timeout_err=1 and remaining set until reset.
